// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding, default widths and
// the assembler-generated branch/jump target table.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int FETCH_PC_W  = 10;
  localparam int FETCH_TGT_W = 4;

  // Regenerated by the assembler for each program; entries wider than PC_W are truncated.
  localparam int BR_TARGETS [16] = '{
    16, 40, 100, 200, 300, 350, 400, 450,
    500, 600, 700, 800, 900, 1000, 1020, 1023
  };

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Combinational target lookup: maps the instruction's target index to a PC
// through the constant BR_TARGETS table.
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int PC_W  = FETCH_PC_W,
  parameter int TGT_W = FETCH_TGT_W
) (
  input  logic [TGT_W-1:0] tgt_idx,
  output logic [PC_W-1:0]  target
);

  always_comb begin
    target = PC_W'(BR_TARGETS[tgt_idx]);
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and run/halt sequencing ahead of the controller.
// Optional macro FETCH_CYCLE_COUNT_EN enables the saturating RUN-cycle counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W       = FETCH_PC_W,
  parameter int TGT_W      = FETCH_TGT_W,
  parameter int START_ADDR = 0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             br_ctrl,
  input  logic             jmp_ctrl,
  input  logic             done_ctrl,
  input  logic             acc_nz,
  input  logic [TGT_W-1:0] tgt_idx,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic             pc_fault,
  output logic [15:0]      cycle_count
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  fetch_state_e    state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            fault_nxt;
  logic [PC_W-1:0] target;

  branch_lut #(.PC_W(PC_W), .TGT_W(TGT_W)) u_lut (
    .tgt_idx (tgt_idx),
    .target  (target)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= START_PC;
      pc_fault <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pc_fault <= fault_nxt;
    end
  end

  // Strict priority in RUN: restart, done, jump, taken branch, sequential.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fault_nxt = pc_fault;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = START_PC;
          fault_nxt = 1'b0;
        end
      end
      RUN: begin
        if (start) begin
          pc_nxt    = START_PC;
          fault_nxt = 1'b0;
        end else if (done_ctrl) begin
          state_nxt = HALT;
        end else if (jmp_ctrl || (br_ctrl && acc_nz)) begin
          pc_nxt = target;
        end else begin
          pc_nxt = pc + 1'b1;
          if (pc == {PC_W{1'b1}}) begin
            state_nxt = HALT;
            fault_nxt = 1'b1;
          end
        end
      end
      HALT: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = START_PC;
          fault_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = START_PC;
      end
    endcase
  end

  always_comb begin
    running = (state == RUN);
    done    = (state == HALT);
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] count_q;

  // Start clears the count even when restarting from RUN.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_q <= 16'h0000;
    end else if (start && (state != HALT || start)) begin
      count_q <= 16'h0000;
    end else if (state == RUN && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'h0001;
    end
  end

  assign cycle_count = count_q;
`else
  assign cycle_count = 16'h0000;
`endif

endmodule
